count_sequence_checker: RTL and testbench
=========================================

COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

Interface
REQ-001 Parameter WIDTH, default 4: width of the observed count value.
REQ-002 Parameter LOCK_CNT, default 2: consecutive correct increments needed to lock.
REQ-003 Parameter CNT_W, default 8: width of err_count and wrap_count.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port q_in  input  WIDTH  count value from the counter under observation.
REQ-007 Port en  input  1  sample enable; q_in is evaluated only on edges where en=1.
REQ-008 Port clear_err  input  1  clears err_sticky and err_count.
REQ-009 Port locked  output  1  high while in state LOCKED.
REQ-010 Port expected  output  WIDTH  next predicted value, (prev+1) mod 2^WIDTH.
REQ-011 Port err_pulse  output  1  one-cycle flag for a sequence violation.
REQ-012 Port restart_pulse  output  1  one-cycle flag for a legal return to 0.
REQ-013 Port err_sticky  output  1  set by any violation; held until clear_err or reset.
REQ-014 Port err_count  output  CNT_W  saturating count of violations.
REQ-015 Port wrap_count  output  CNT_W  count of correct 2^WIDTH-1 -> 0 wraps while locked; wraps modulo 2^CNT_W.

Function
REQ-016 The checker SHALL use states IDLE, ACQUIRE and LOCKED; all outputs SHALL be registered.
REQ-017 On an edge with en=0, all state, registers and sticky outputs SHALL hold, and both pulse outputs SHALL be 0.
REQ-018 IDLE, en=1: the checker SHALL set prev=q_in, set match_cnt=0 and go to ACQUIRE.
REQ-019 ACQUIRE, en=1, q_in==expected: match_cnt SHALL increment, and the checker SHALL go to LOCKED on the same edge that match_cnt reaches LOCK_CNT.
REQ-020 ACQUIRE, en=1, q_in!=expected: match_cnt SHALL be set to 0; no error SHALL be flagged.
REQ-021 LOCKED, en=1, q_in==expected: the checker SHALL stay in LOCKED; if expected==0, wrap_count SHALL increment.
REQ-022 LOCKED, en=1, q_in==0 and expected!=0: restart_pulse SHALL be set, match_cnt SHALL be set to 0, the checker SHALL go to ACQUIRE, and no error SHALL be flagged.
REQ-023 LOCKED, en=1, any other mismatch: err_pulse SHALL be set, err_sticky SHALL be set, err_count SHALL increment (saturating at 2^CNT_W-1), match_cnt SHALL be set to 0, and the checker SHALL go to ACQUIRE.
REQ-024 prev SHALL be loaded with q_in on every en=1 edge in every state.
REQ-025 Latency: the response to the sample taken at edge k SHALL be visible immediately after edge k; each pulse SHALL last exactly one cycle.
REQ-026 clear_err=1 on the same edge as a new error: err_sticky SHALL be 1 and err_count SHALL be 1.
REQ-027 clear_err=1 with no new error: err_sticky SHALL be 0 and err_count SHALL be 0; all other state SHALL be unaffected.

Reset
REQ-028 reset=1 at an edge SHALL force state=IDLE, prev=0, match_cnt=0, and locked=0, expected=1, err_pulse=0, restart_pulse=0, err_sticky=0, err_count=0, wrap_count=0.
REQ-029 reset SHALL take priority over en and clear_err, including when asserted mid-lock.

Structure
REQ-030 The state enum and the default WIDTH, LOCK_CNT and CNT_W values SHALL reside in the shared package count_chk_pkg.
REQ-031 err_count SHALL be implemented by the sub-module count_chk_sat_cnt (parameterised saturating counter with inc and clr inputs).

Verification
REQ-032 Scenario: reset, then en=1 with q_in=0,1,2,3 -> locked=1 after the sample of 2; err_pulse=0 throughout.
REQ-033 Scenario: locked, q_in runs 13,14,15,0,1 -> wrap_count=1 after the 0 sample; no errors.
REQ-034 Scenario: locked, q_in 5,6,9 -> one err_pulse after the 9 sample; err_sticky=1, err_count=1, locked=0; then 10,11 -> locked=1 again.
REQ-035 Scenario: locked at 7, q_in=0 -> restart_pulse=1 for one cycle, err_count unchanged; relock after 1,2.
REQ-036 Scenario: force 300 violations with CNT_W=8 -> err_count=255; violation together with clear_err -> err_count=1, err_sticky=1.
REQ-037 Scenario: en=0 for 5 cycles while q_in changes randomly, then reset asserted mid-lock -> no state change while en=0; all outputs at REQ-028 values after the reset edge.

Source files
------------

// File: rtl/count_chk_pkg.sv
// Shared types and default sizing for the count sequence checker.
package count_chk_pkg;

  localparam int unsigned CHK_WIDTH    = 4;
  localparam int unsigned CHK_LOCK_CNT = 2;
  localparam int unsigned CHK_CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } chk_state_e;

endpackage

// File: rtl/count_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear and increment on the
// same edge restart the count at one.
module count_chk_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear dominates, increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W'(1) : '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Watches a free-running counter and flags values that break the +1 sequence
// once the checker has locked onto it. A return to zero while locked is
// treated as a legal restart rather than an error.
module count_sequence_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH    = CHK_WIDTH,
  parameter int unsigned LOCK_CNT = CHK_LOCK_CNT,
  parameter int unsigned CNT_W    = CHK_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             en,
  input  logic             clear_err,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             err_pulse,
  output logic             restart_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  localparam int unsigned MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_VAL = MW'(LOCK_CNT);

  chk_state_e       state_q,         state_d;
  logic [MW-1:0]    match_cnt_q,     match_cnt_d;
  // expected_q always holds (prev + 1), so prev itself needs no separate flop.
  logic [WIDTH-1:0] expected_q,      expected_d;
  logic             locked_q,        locked_d;
  logic             err_pulse_q,     err_pulse_d;
  logic             restart_pulse_q, restart_pulse_d;
  logic             err_sticky_q,    err_sticky_d;
  logic [CNT_W-1:0] wrap_count_q,    wrap_count_d;
  logic             err_inc_c;

  // Sequence tracking: next state, prediction and event flags for this sample.
  always_comb begin
    state_d         = state_q;
    match_cnt_d     = match_cnt_q;
    expected_d      = expected_q;
    locked_d        = locked_q;
    err_pulse_d     = 1'b0;
    restart_pulse_d = 1'b0;
    wrap_count_d    = wrap_count_q;
    err_inc_c       = 1'b0;

    if (en) begin
      expected_d = q_in + WIDTH'(1);
      unique case (state_q)
        ST_IDLE: begin
          match_cnt_d = '0;
          state_d     = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (q_in == expected_q) begin
            match_cnt_d = match_cnt_q + MW'(1);
            if (match_cnt_d == LOCK_VAL) begin
              state_d = ST_LOCKED;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (q_in == expected_q) begin
            if (expected_q == '0) begin
              wrap_count_d = wrap_count_q + CNT_W'(1);
            end
          end else if (q_in == '0) begin
            restart_pulse_d = 1'b1;
            match_cnt_d     = '0;
            state_d         = ST_ACQUIRE;
          end else begin
            err_pulse_d = 1'b1;
            err_inc_c   = 1'b1;
            match_cnt_d = '0;
            state_d     = ST_ACQUIRE;
          end
        end
        default: begin
          match_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      endcase
      locked_d = (state_d == ST_LOCKED);
    end

    // A new error wins over a simultaneous clear.
    err_sticky_d = err_inc_c | (err_sticky_q & ~clear_err);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      match_cnt_q     <= '0;
      expected_q      <= WIDTH'(1);
      locked_q        <= 1'b0;
      err_pulse_q     <= 1'b0;
      restart_pulse_q <= 1'b0;
      err_sticky_q    <= 1'b0;
      wrap_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      match_cnt_q     <= match_cnt_d;
      expected_q      <= expected_d;
      locked_q        <= locked_d;
      err_pulse_q     <= err_pulse_d;
      restart_pulse_q <= restart_pulse_d;
      err_sticky_q    <= err_sticky_d;
      wrap_count_q    <= wrap_count_d;
    end
  end

  // Violation counter.
  count_chk_sat_cnt #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc_c),
    .clr   (clear_err),
    .count (err_count)
  );

  assign locked        = locked_q;
  assign expected      = expected_q;
  assign err_pulse     = err_pulse_q;
  assign restart_pulse = restart_pulse_q;
  assign err_sticky    = err_sticky_q;
  assign wrap_count    = wrap_count_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Bench for count_sequence_checker: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the sequence rules.
module tb_count_sequence_checker;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 2;
  localparam int CNT_W    = 8;
  localparam int MODV     = 1 << WIDTH;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] q_in;
  logic             en;
  logic             clear_err;
  logic             locked;
  logic [WIDTH-1:0] expected;
  logic             err_pulse;
  logic             restart_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;

  int n_checks;
  int n_pass;

  // Behavioural model
  bit m_started;
  bit m_locked;
  int m_streak;
  int m_prev;
  bit m_err_p;
  bit m_rst_p;
  bit m_sticky;
  int m_err_cnt;
  int m_wrap;

  count_sequence_checker #(
    .WIDTH    (WIDTH),
    .LOCK_CNT (LOCK_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .q_in          (q_in),
    .en            (en),
    .clear_err     (clear_err),
    .locked        (locked),
    .expected      (expected),
    .err_pulse     (err_pulse),
    .restart_pulse (restart_pulse),
    .err_sticky    (err_sticky),
    .err_count     (err_count),
    .wrap_count    (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_update(input bit e, input int q, input bit c, input bit r);
    int pred;
    if (r) begin
      m_started = 0; m_locked = 0; m_streak = 0; m_prev = 0;
      m_err_p = 0; m_rst_p = 0; m_sticky = 0; m_err_cnt = 0; m_wrap = 0;
      return;
    end
    m_err_p = 0;
    m_rst_p = 0;
    if (e) begin
      pred = (m_prev + 1) % MODV;
      if (!m_started) begin
        m_started = 1;
        m_streak  = 0;
      end else if (m_locked) begin
        if (q == pred) begin
          if (pred == 0) m_wrap = (m_wrap + 1) % (CMAX + 1);
        end else if (q == 0) begin
          m_rst_p = 1; m_locked = 0; m_streak = 0;
        end else begin
          m_err_p = 1; m_locked = 0; m_streak = 0;
        end
      end else begin
        if (q == pred) begin
          m_streak++;
          if (m_streak == LOCK_CNT) m_locked = 1;
        end else begin
          m_streak = 0;
        end
      end
      m_prev = q;
    end
    if (c) begin
      m_sticky  = m_err_p;
      m_err_cnt = m_err_p ? 1 : 0;
    end else if (m_err_p) begin
      m_sticky  = 1;
      m_err_cnt = (m_err_cnt < CMAX) ? m_err_cnt + 1 : CMAX;
    end
  endtask

  // One clock: drive on the falling edge, compare all outputs just after the rising edge.
  task automatic step(input bit e, input int q, input bit c, input bit r);
    @(negedge clk);
    en        = e;
    q_in      = WIDTH'(q);
    clear_err = c;
    reset     = r;
    @(posedge clk);
    model_update(e, q, c, r);
    #1;
    check("locked",        32'(locked),        32'(m_locked));
    check("expected",      32'(expected),      32'((m_prev + 1) % MODV));
    check("err_pulse",     32'(err_pulse),     32'(m_err_p));
    check("restart_pulse", 32'(restart_pulse), 32'(m_rst_p));
    check("err_sticky",    32'(err_sticky),    32'(m_sticky));
    check("err_count",     32'(err_count),     32'(m_err_cnt));
    check("wrap_count",    32'(wrap_count),    32'(m_wrap));
  endtask

  task automatic run(input int q);
    step(1'b1, q, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_locked"},  32'(locked),        32'd0);
    check({tag, "_exp"},     32'(expected),      32'd1);
    check({tag, "_errp"},    32'(err_pulse),     32'd0);
    check({tag, "_rstp"},    32'(restart_pulse), 32'd0);
    check({tag, "_sticky"},  32'(err_sticky),    32'd0);
    check({tag, "_errcnt"},  32'(err_count),     32'd0);
    check({tag, "_wrap"},    32'(wrap_count),    32'd0);
  endtask

  initial begin
    int bad;
    int rq;
    bit re;
    n_checks = 0;
    n_pass   = 0;
    en = 0; q_in = '0; clear_err = 0; reset = 1;

    // Reset and initial acquisition
    step(1'b0, 0, 1'b0, 1'b1);
    check_reset_values("rst0");
    run(0); run(1);
    check("acq_not_locked", 32'(locked), 32'd0);
    run(2);
    check("lock_after_2", 32'(locked), 32'd1);
    run(3);

    // Wrap while locked
    for (int v = 4; v <= 15; v++) run(v);
    run(0);
    check("wrap_once", 32'(wrap_count), 32'd1);
    run(1);
    check("wrap_no_err", 32'(err_sticky), 32'd0);

    // Violation then relock
    for (int v = 2; v <= 6; v++) run(v);
    run(9);
    check("viol_pulse",  32'(err_pulse),  32'd1);
    check("viol_cnt",    32'(err_count),  32'd1);
    check("viol_unlock", 32'(locked),     32'd0);
    run(10);
    check("viol_pulse_1cyc", 32'(err_pulse), 32'd0);
    run(11);
    check("viol_relock", 32'(locked), 32'd1);

    // Clear without a new error
    step(1'b1, 12, 1'b1, 1'b0);
    check("clr_sticky", 32'(err_sticky), 32'd0);
    check("clr_locked", 32'(locked),     32'd1);

    // Legal restart at 7
    for (int v = 13; v <= 15; v++) run(v);
    for (int v = 0; v <= 7; v++) run(v);
    run(0);
    check("restart_pulse", 32'(restart_pulse), 32'd1);
    check("restart_nocnt", 32'(err_count),     32'd0);
    run(1);
    check("restart_1cyc", 32'(restart_pulse), 32'd0);
    run(2);
    check("restart_relock", 32'(locked), 32'd1);

    // Saturate the error counter
    for (int i = 0; i < 300; i++) begin
      bad = (m_prev + 5) % MODV;
      if (bad == 0) bad = (m_prev + 6) % MODV;
      run(bad);
      run((bad + 1) % MODV);
      run((bad + 2) % MODV);
    end
    check("sat_cnt", 32'(err_count), 32'(CMAX));
    bad = (m_prev + 5) % MODV;
    if (bad == 0) bad = (m_prev + 6) % MODV;
    step(1'b1, bad, 1'b1, 1'b0);
    check("clr_and_err_cnt",    32'(err_count),  32'd1);
    check("clr_and_err_sticky", 32'(err_sticky), 32'd1);

    // Relock, hold with en=0, then reset mid-lock
    run((bad + 1) % MODV);
    run((bad + 2) % MODV);
    check("hold_prelock", 32'(locked), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, $urandom_range(0, MODV - 1), 1'b0, 1'b0);
    check("hold_locked", 32'(locked),   32'd1);
    check("hold_exp",    32'(expected), 32'((bad + 3) % MODV));
    step(1'b1, 5, 1'b1, 1'b1);
    check_reset_values("rst_mid");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      re = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: rq = (m_prev + 1) % MODV;
        7:                   rq = 0;
        default:             rq = $urandom_range(0, MODV - 1);
      endcase
      step(re, rq, re && ($urandom_range(0, 15) == 0), $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
